// File: rtl/rgb_to_gray_pkg.sv
// Shared constants and stage types for the rgb_to_gray pixel converter.
// Holds default coefficients, register map, pipeline latency and frame-info field layout.
package rgb_to_gray_pkg;

  localparam logic [7:0]  DEF_KR   = 8'd77;
  localparam logic [7:0]  DEF_KG   = 8'd150;
  localparam logic [7:0]  DEF_KB   = 8'd29;
  localparam logic [23:0] DEF_COEF = {DEF_KR, DEF_KG, DEF_KB};

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_COEF = 2'd1
  } reg_addr_e;

  localparam int PIPE_LATENCY  = 3;
  localparam int FI_FIELD_W    = 16;
  localparam int FI_WIDTH_LSB  = 20;
  localparam int FI_HEIGHT_LSB = 4;

  typedef struct packed {
    logic        valid;
    logic [15:0] pr;
    logic [15:0] pg;
    logic [15:0] pb;
    logic [7:0]  g;
    logic        bypass;
    logic        eop;
  } mul_stage_t;

  typedef struct packed {
    logic        valid;
    logic [17:0] acc;
    logic [7:0]  g;
    logic        bypass;
    logic        eop;
  } sum_stage_t;

  // Rounding offset is already folded into acc; drop the fraction and clamp.
  function automatic logic [7:0] sat255(input logic [17:0] acc);
    logic [9:0] q;
    q = acc[17:8];
    return (q > 10'd255) ? 8'hFF : q[7:0];
  endfunction

endpackage

// File: rtl/rgb_to_gray_mac.sv
// Three-stage multiply / sum / round-saturate datapath for one pixel per cycle.
// The whole pipe advances together when en is high and holds otherwise.
module rgb_to_gray_mac
  import rgb_to_gray_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic [23:0] in_rgb,
  input  logic [23:0] in_coef,
  input  logic        in_bypass,
  input  logic        in_eop,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_eop
);

  mul_stage_t s1_d, s1_q;
  sum_stage_t s2_d, s2_q;
  logic       s3_valid_d, s3_valid_q;
  logic [7:0] s3_data_d, s3_data_q;
  logic       s3_eop_d, s3_eop_q;

  always_comb begin
    s1_d       = s1_q;
    s2_d       = s2_q;
    s3_valid_d = s3_valid_q;
    s3_data_d  = s3_data_q;
    s3_eop_d   = s3_eop_q;
    if (en) begin
      s1_d.valid  = in_valid;
      s1_d.pr     = 16'(in_rgb[23:16]) * 16'(in_coef[23:16]);
      s1_d.pg     = 16'(in_rgb[15:8])  * 16'(in_coef[15:8]);
      s1_d.pb     = 16'(in_rgb[7:0])   * 16'(in_coef[7:0]);
      s1_d.g      = in_rgb[15:8];
      s1_d.bypass = in_bypass;
      s1_d.eop    = in_eop;

      s2_d.valid  = s1_q.valid;
      s2_d.acc    = 18'(s1_q.pr) + 18'(s1_q.pg) + 18'(s1_q.pb) + 18'd128;
      s2_d.g      = s1_q.g;
      s2_d.bypass = s1_q.bypass;
      s2_d.eop    = s1_q.eop;

      s3_valid_d  = s2_q.valid;
      s3_data_d   = s2_q.bypass ? s2_q.g : sat255(s2_q.acc);
      s3_eop_d    = s2_q.valid && s2_q.eop;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= 8'd0;
      s3_eop_q   <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_valid_q <= s3_valid_d;
      s3_data_q  <= s3_data_d;
      s3_eop_q   <= s3_eop_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_data  = s3_data_q;
  assign out_eop   = s3_eop_q;

endmodule

// File: rtl/rgb_to_gray.sv
// RGB to gray streaming converter with frame tracking and a small control slave.
// Define RGB_TO_GRAY_PROG_COEF_EN to make the kr/kg/kb coefficients writable.
module rgb_to_gray
  import rgb_to_gray_pkg::*;
#(
  parameter int W = 960,
  parameter int H = 540
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] asi_in0_data,
  input  logic        asi_in0_valid,
  output logic        asi_in0_ready,
  output logic [7:0]  aso_out0_data,
  output logic        aso_out0_valid,
  input  logic        aso_out0_ready,
  output logic        aso_out0_eop,
  input  logic [35:0] asi_in1_data,
  input  logic        asi_in1_valid,
  output logic [35:0] aso_out1_data,
  output logic        aso_out1_valid,
  input  logic [31:0] avs_s0_writedata,
  input  logic        avs_s0_write,
  input  logic [1:0]  avs_s0_address
);

  logic [15:0] shadow_w_d, shadow_w_q, shadow_h_d, shadow_h_q;
  logic [15:0] active_w_d, active_w_q, active_h_d, active_h_q;
  logic        shadow_byp_d, shadow_byp_q, active_byp_d, active_byp_q;
  logic [15:0] x_d, x_q, y_d, y_q;
  logic [35:0] out1_data_d, out1_data_q;
  logic        out1_valid_d, out1_valid_q;
  logic        stall_n, accept, frame_start, bypass_use, beat_eop;
  logic [15:0] w_use, h_use;
  logic [23:0] coef_use;
  logic        unused_wdata;

  assign stall_n       = !aso_out0_valid || aso_out0_ready;
  assign asi_in0_ready = stall_n;
  assign accept        = asi_in0_valid && stall_n;
  assign frame_start   = accept && (x_q == 16'd0) && (y_q == 16'd0);

  // The first beat of a frame already sees the freshly promoted shadow set.
  assign w_use      = frame_start ? shadow_w_q   : active_w_q;
  assign h_use      = frame_start ? shadow_h_q   : active_h_q;
  assign bypass_use = frame_start ? shadow_byp_q : active_byp_q;
  assign beat_eop   = (x_q == w_use - 16'd1) && (y_q == h_use - 16'd1);

  always_comb begin
    shadow_w_d   = shadow_w_q;
    shadow_h_d   = shadow_h_q;
    shadow_byp_d = shadow_byp_q;
    active_w_d   = active_w_q;
    active_h_d   = active_h_q;
    active_byp_d = active_byp_q;
    x_d          = x_q;
    y_d          = y_q;
    out1_data_d  = asi_in1_valid ? asi_in1_data : out1_data_q;
    out1_valid_d = asi_in1_valid;
    if (asi_in1_valid) begin
      shadow_w_d = asi_in1_data[FI_WIDTH_LSB +: FI_FIELD_W];
      shadow_h_d = asi_in1_data[FI_HEIGHT_LSB +: FI_FIELD_W];
    end
    if (avs_s0_write && (avs_s0_address == REG_CTRL))
      shadow_byp_d = avs_s0_writedata[0];
    if (frame_start) begin
      active_w_d   = shadow_w_q;
      active_h_d   = shadow_h_q;
      active_byp_d = shadow_byp_q;
    end
    // eop is tagged at acceptance and rides the pipe, so it pairs with the same beat at the output.
    if (accept) begin
      if (x_q == w_use - 16'd1) begin
        x_d = 16'd0;
        y_d = (y_q == h_use - 16'd1) ? 16'd0 : y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_w_q   <= 16'(W);
      shadow_h_q   <= 16'(H);
      active_w_q   <= 16'(W);
      active_h_q   <= 16'(H);
      shadow_byp_q <= 1'b0;
      active_byp_q <= 1'b0;
      x_q          <= 16'd0;
      y_q          <= 16'd0;
      out1_data_q  <= 36'd0;
      out1_valid_q <= 1'b0;
    end else begin
      shadow_w_q   <= shadow_w_d;
      shadow_h_q   <= shadow_h_d;
      active_w_q   <= active_w_d;
      active_h_q   <= active_h_d;
      shadow_byp_q <= shadow_byp_d;
      active_byp_q <= active_byp_d;
      x_q          <= x_d;
      y_q          <= y_d;
      out1_data_q  <= out1_data_d;
      out1_valid_q <= out1_valid_d;
    end
  end

`ifdef RGB_TO_GRAY_PROG_COEF_EN
  logic [23:0] shadow_coef_d, shadow_coef_q, active_coef_d, active_coef_q;

  always_comb begin
    shadow_coef_d = shadow_coef_q;
    active_coef_d = active_coef_q;
    if (avs_s0_write && (avs_s0_address == REG_COEF))
      shadow_coef_d = avs_s0_writedata[23:0];
    if (frame_start)
      active_coef_d = shadow_coef_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_coef_q <= DEF_COEF;
      active_coef_q <= DEF_COEF;
    end else begin
      shadow_coef_q <= shadow_coef_d;
      active_coef_q <= active_coef_d;
    end
  end

  assign coef_use     = frame_start ? shadow_coef_q : active_coef_q;
  assign unused_wdata = ^avs_s0_writedata[31:24];
`else
  assign coef_use     = DEF_COEF;
  assign unused_wdata = ^avs_s0_writedata[31:1];
`endif

  rgb_to_gray_mac u_mac (
    .clk       (clk),
    .rst       (rst),
    .en        (stall_n),
    .in_valid  (accept),
    .in_rgb    (asi_in0_data),
    .in_coef   (coef_use),
    .in_bypass (bypass_use),
    .in_eop    (beat_eop),
    .out_valid (aso_out0_valid),
    .out_data  (aso_out0_data),
    .out_eop   (aso_out0_eop)
  );

  assign aso_out1_data  = out1_data_q;
  assign aso_out1_valid = out1_valid_q;

endmodule

// File: doc/rgb_to_gray.md
RGB_TO_GRAY -- requirements
Module: rgb_to_gray

Interface
REQ-001 SHALL have parameter W, default 960, meaning default frame width in pixels.
REQ-002 SHALL have parameter H, default 540, meaning default frame height in lines.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port asi_in0_data  input  24  RGB pixel {R[23:16],G[15:8],B[7:0]}.
REQ-006 SHALL have ports asi_in0_valid input 1 and asi_in0_ready output 1, the pixel-in handshake.
REQ-007 SHALL have port aso_out0_data  output  8  gray pixel to the histogram stage.
REQ-008 SHALL have ports aso_out0_valid output 1, aso_out0_ready input 1 and aso_out0_eop output 1, the last-pixel-of-frame flag.
REQ-009 SHALL have ports asi_in1_data input 36 and asi_in1_valid input 1: frame info, width [35:20], height [19:4].
REQ-010 SHALL have ports aso_out1_data output 36 and aso_out1_valid output 1: frame info, registered pass-through.
REQ-011 SHALL have ports avs_s0_writedata input 32, avs_s0_write input 1 and avs_s0_address input 2, a write-only control slave.

Function
REQ-012 SHALL compute gray = sat255((R*kr + G*kg + B*kb + 128) >> 8), using an 18-bit unsigned accumulator.
REQ-013 SHALL implement a 3-stage pipeline (multiply, sum, round/saturate), latency exactly 3 cycles when unstalled.
REQ-014 SHALL accept a beat only when asi_in0_valid && asi_in0_ready, with asi_in0_ready = !s3_valid || aso_out0_ready.
REQ-015 SHALL freeze all stages while s3_valid && !aso_out0_ready, holding aso_out0_data and aso_out0_valid stable and losing no beat.
REQ-016 SHALL sustain 1 pixel/cycle with no bubbles when aso_out0_ready stays high.
REQ-017 SHALL latch frame info on asi_in1_valid into shadow width/height registers.
REQ-018 SHALL forward frame info to aso_out1 one cycle after asi_in1_valid.
REQ-019 SHALL count output beats (x,y) and assert aso_out0_eop with the beat at x==width-1 && y==height-1, then wrap to (0,0).
REQ-020 SHALL copy the shadow width/height and shadow coefficients into the active set only at frame start, i.e. when the input-side counter is (0,0) and a beat is accepted.
REQ-021 SHALL decode register writes as follows: address 0 bit0 = bypass; address 1 [23:0] = {kr,kg,kb}; addresses 2-3 ignored.
REQ-022 SHALL make bypass, when set, output G unchanged, with the same latency and handshake.
REQ-023 SHALL make a coefficient sum above 256 saturate the output at 255, never wrap.
REQ-024 SHALL, when a register write and a frame start coincide, let the old shadow values take effect and apply the new write at the next frame.

Reset
REQ-025 SHALL, while rst is low, clear all pipeline valids, aso_out0_valid, aso_out0_eop, aso_out0_data, aso_out1_valid and the counters to 0.
REQ-026 SHALL reset width/height to W/H, coefficients to {77,150,29} and bypass to 0.
REQ-027 SHALL drop every in-flight pixel on reset mid-frame and restart the next frame at (0,0).

Configuration
REQ-028 SHALL, with RGB_TO_GRAY_PROG_COEF_EN defined, make kr/kg/kb writable via address 1.
REQ-029 SHALL, without RGB_TO_GRAY_PROG_COEF_EN, hard-wire the coefficients to {77,150,29} and ignore address-1 writes; bypass stays functional.

Structure
REQ-030 SHALL place the default coefficients, register address map, pipeline latency constant and frame-info field positions in package rgb_to_gray_pkg.
REQ-031 SHALL isolate the multiply/sum/saturate datapath in sub-module rgb_to_gray_mac with a single stall-enable input.

Verification
REQ-032 SHALL cover: reset defaults, input (255,255,255) -> gray 255; (0,0,0) -> 0; (100,50,200) -> 82; output exactly 3 cycles after acceptance.
REQ-033 SHALL cover: a 4x2 frame via asi_in1 with 8 beats streamed -> aso_out0_eop only on beat 8, then counters wrap.
REQ-034 SHALL cover: aso_out0_ready toggled randomly over 1000 pixels -> output sequence identical to the reference model, no drop or duplicate.
REQ-035 SHALL cover: coefficients {200,200,200} written mid-frame -> current frame still uses 77/150/29; next frame with input (128,128,128) -> 255 saturated.
REQ-036 SHALL cover: bypass=1 written mid-frame -> takes effect at next frame, output equals G for input (10,99,7) -> 99.
REQ-037 SHALL cover: rst pulsed low mid-frame with a full pipeline -> aso_out0_valid low next cycle, no stale beat after release.
